// File: rtl/button_step_pkg.sv
// -----------------------------------------------------------------------------
// button_step_pkg
// Shared definitions for the push-button step conditioner.
//   DIR_E/W/N/S : bit index of each direction in the 4-bit held/step vectors
//   state_t     : repeat FSM states (idle, initial delay, auto-repeat)
//   cnt_width() : counter width able to hold 0 .. max_count-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package button_step_pkg;

   localparam int DIR_E    = 0;
   localparam int DIR_W    = 1;
   localparam int DIR_N    = 2;
   localparam int DIR_S    = 3;
   localparam int NUM_DIRS = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Two-flop synchroniser followed by a counting debouncer for one raw button.
// The stable level flips only after the synchronised input has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
// Ports:
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous active-low reset
//   btn_i    in   raw asynchronous button, active-high
//   stable_o out  debounced level
// -----------------------------------------------------------------------------
module button_debouncer
   import button_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_i,
   output logic stable_o
);

   localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             stable_q;
   logic             stable_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= btn_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   // Counter only runs while the synchronised input disagrees; it clears on
   // agreement and on the flip itself, so it never wraps.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/button_step_conditioner.sv
// -----------------------------------------------------------------------------
// button_step_conditioner
// Front-end for the cursor position stage: debounces the four board buttons
// and emits a registered move tick on press, then auto-repeat ticks while any
// button stays held. Each tick carries per-direction step strobes sampled
// from the debounced levels at the moment the tick is decided; opposing
// directions held together cancel.
// Optional build macro: BUTTON_STEP_ACCEL_EN -- after ACCEL_AFTER repeat ticks
// the repeat period halves (minimum 1 cycle) until all buttons are released.
// Ports:
//   clk_in                 in   system clock
//   rst_n_in               in   asynchronous active-low reset
//   BTN_EAST/WEST/NORTH/SOUTH in raw asynchronous buttons, active-high
//   held[3:0]              out  debounced levels, bit0=E bit1=W bit2=N bit3=S
//   move_tick              out  one-cycle pulse per step event
//   step_east/west/north/south out direction strobes, only with move_tick
// -----------------------------------------------------------------------------
module button_step_conditioner
   import button_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 1000000
`ifdef BUTTON_STEP_ACCEL_EN
   ,
   parameter int ACCEL_AFTER     = 16
`endif
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       BTN_EAST,
   input  logic       BTN_WEST,
   input  logic       BTN_NORTH,
   input  logic       BTN_SOUTH,
   output logic [3:0] held,
   output logic       move_tick,
   output logic       step_east,
   output logic       step_west,
   output logic       step_north,
   output logic       step_south
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = cnt_width(CNT_MAX);

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [NUM_DIRS-1:0] btn_raw;
   logic [NUM_DIRS-1:0] held_w;
   logic                any_held;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic                tick_q;
   logic                tick_d;
   logic [NUM_DIRS-1:0] step_q;
   logic [NUM_DIRS-1:0] step_d;
   logic [CNT_W-1:0]    period_last;

   assign btn_raw[DIR_E] = BTN_EAST;
   assign btn_raw[DIR_W] = BTN_WEST;
   assign btn_raw[DIR_N] = BTN_NORTH;
   assign btn_raw[DIR_S] = BTN_SOUTH;

   for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_deb
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i   (clk_in),
         .rst_n_i (rst_n_in),
         .btn_i   (btn_raw[gi]),
         .stable_o(held_w[gi])
      );
   end

   assign any_held = |held_w;

`ifdef BUTTON_STEP_ACCEL_EN
   localparam int FAST_PERIOD = ((REPEAT_PERIOD >> 1) < 1) ? 1 : (REPEAT_PERIOD >> 1);
   localparam int ACC_W       = cnt_width(ACCEL_AFTER + 1);

   localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_PERIOD - 1);
   localparam logic [ACC_W-1:0] ACC_LAST  = ACC_W'(ACCEL_AFTER);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Counts only ticks issued from REPEAT (not the end-of-delay tick) and
   // saturates, so the fast period sticks until the buttons are released.
   always_comb begin
      acc_d = acc_q;
      if (state_q == ST_IDLE) begin
         acc_d = '0;
      end else if ((state_q == ST_REPEAT) && tick_d && (acc_q != ACC_LAST)) begin
         acc_d = acc_q + ACC_W'(1);
      end
   end

   assign period_last = (acc_q == ACC_LAST) ? FAST_LAST : PERIOD_LAST;
`else
   assign period_last = PERIOD_LAST;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         step_q  <= step_d;
      end
   end

   // Release always wins over a pending tick so a let-go button never steps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (any_held) begin
               tick_d  = 1'b1;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (!any_held) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == DELAY_LAST) begin
               tick_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_REPEAT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_REPEAT: begin
            if (!any_held) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == period_last) begin
               tick_d = 1'b1;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Direction mask comes from the levels at decision time, so a button added
   // mid-hold simply joins the next tick; opposing pairs cancel each other.
   always_comb begin
      step_d        = '0;
      step_d[DIR_E] = tick_d & held_w[DIR_E] & ~held_w[DIR_W];
      step_d[DIR_W] = tick_d & held_w[DIR_W] & ~held_w[DIR_E];
      step_d[DIR_N] = tick_d & held_w[DIR_N] & ~held_w[DIR_S];
      step_d[DIR_S] = tick_d & held_w[DIR_S] & ~held_w[DIR_N];
   end

   assign held       = held_w;
   assign move_tick  = tick_q;
   assign step_east  = step_q[DIR_E];
   assign step_west  = step_q[DIR_W];
   assign step_north = step_q[DIR_N];
   assign step_south = step_q[DIR_S];

endmodule

// File: tb/tb_button_step_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_step_conditioner
// Randomised and directed stimulus for button_step_conditioner, compared every
// cycle against a behavioural model expressed as run lengths and absolute tick
// schedules, plus literal tick-time checks for the directed scenarios.
// Build with BUTTON_STEP_ACCEL_EN to include the acceleration scenario.
// -----------------------------------------------------------------------------
module tb_button_step_conditioner;
   import button_step_pkg::*;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 5;
`ifdef BUTTON_STEP_ACCEL_EN
   localparam int AA   = 3;
   localparam int FAST = ((RP >> 1) < 1) ? 1 : (RP >> 1);
`endif

   localparam logic [3:0] M_E = 4'b0001;
   localparam logic [3:0] M_W = 4'b0010;
   localparam logic [3:0] M_N = 4'b0100;
   localparam logic [3:0] M_S = 4'b1000;

   logic       clk_in    = 1'b0;
   logic       rst_n_in  = 1'b0;
   logic       BTN_EAST  = 1'b0;
   logic       BTN_WEST  = 1'b0;
   logic       BTN_NORTH = 1'b0;
   logic       BTN_SOUTH = 1'b0;
   logic [3:0] held;
   logic       move_tick;
   logic       step_east;
   logic       step_west;
   logic       step_north;
   logic       step_south;

   int checks = 0;
   int passed = 0;
   int ncyc   = 0;

   int         tick_at[$];
   logic [3:0] tick_mask[$];
   logic [3:0] held_or = 4'b0;

   // behavioural model state
   int         m_n = 0;
   int         m_next = 0;
   int         m_last_eq[4] = '{0, 0, 0, 0};
   logic [3:0] m_s1 = 4'b0;
   logic [3:0] m_s2 = 4'b0;
   logic [3:0] m_stable = 4'b0;
   logic [3:0] m_step = 4'b0;
   logic       m_tick = 1'b0;
   bit         m_active = 1'b0;
`ifdef BUTTON_STEP_ACCEL_EN
   bit         m_in_rep = 1'b0;
   int         m_rep = 0;
`endif

   button_step_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
`ifdef BUTTON_STEP_ACCEL_EN
      ,
      .ACCEL_AFTER    (AA)
`endif
   ) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .BTN_EAST  (BTN_EAST),
      .BTN_WEST  (BTN_WEST),
      .BTN_NORTH (BTN_NORTH),
      .BTN_SOUTH (BTN_SOUTH),
      .held      (held),
      .move_tick (move_tick),
      .step_east (step_east),
      .step_west (step_west),
      .step_north(step_north),
      .step_south(step_south)
   );

   initial forever #5 clk_in = ~clk_in;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
   endtask

   function automatic int dut_vec();
      return int'({held, move_tick, step_south, step_north, step_west, step_east});
   endfunction

   task automatic set_btn(input logic [3:0] m);
      BTN_EAST  = m[DIR_E];
      BTN_WEST  = m[DIR_W];
      BTN_NORTH = m[DIR_N];
      BTN_SOUTH = m[DIR_S];
   endtask

   task automatic clear_log();
      tick_at.delete();
      tick_mask.delete();
      held_or = 4'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic check_tick(input string name, input int idx, input int base,
                             input int off, input logic [3:0] mask);
      if (idx < tick_at.size()) begin
         check(name, tick_at[idx] - base, off);
         check({name, "_mask"}, int'(tick_mask[idx]), int'(mask));
      end else begin
         check(name, -1, off);
      end
   endtask

   // Model: a button's stable level flips once the synchronised input has
   // disagreed for DB straight cycles; ticks follow an absolute schedule.
   task automatic model_step();
      logic [3:0] h_pre;
      logic [3:0] s_pre;
      h_pre = m_stable;
      s_pre = m_s2;
      m_n++;
      for (int i = 0; i < 4; i++) begin
         if (s_pre[i] == m_stable[i]) begin
            m_last_eq[i] = m_n;
         end else if (m_n - m_last_eq[i] >= DB) begin
            m_stable[i]  = ~m_stable[i];
            m_last_eq[i] = m_n;
         end
      end
      m_s2   = m_s1;
      m_s1   = {BTN_SOUTH, BTN_NORTH, BTN_WEST, BTN_EAST};
      m_tick = 1'b0;
      if (h_pre == 4'b0) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         m_tick   = 1'b1;
         m_active = 1'b1;
         m_next   = m_n + RD;
`ifdef BUTTON_STEP_ACCEL_EN
         m_in_rep = 1'b0;
         m_rep    = 0;
`endif
      end else if (m_n == m_next) begin
         m_tick = 1'b1;
`ifdef BUTTON_STEP_ACCEL_EN
         if (m_in_rep && m_rep < AA) m_rep++;
         m_in_rep = 1'b1;
         m_next   = m_n + ((m_rep >= AA) ? FAST : RP);
`else
         m_next   = m_n + RP;
`endif
      end
      m_step[DIR_E] = m_tick & h_pre[DIR_E] & ~h_pre[DIR_W];
      m_step[DIR_W] = m_tick & h_pre[DIR_W] & ~h_pre[DIR_E];
      m_step[DIR_N] = m_tick & h_pre[DIR_N] & ~h_pre[DIR_S];
      m_step[DIR_S] = m_tick & h_pre[DIR_S] & ~h_pre[DIR_N];
   endtask

   task automatic model_reset();
      m_n = 0; m_next = 0;
      for (int i = 0; i < 4; i++) m_last_eq[i] = 0;
      m_s1 = 4'b0; m_s2 = 4'b0; m_stable = 4'b0; m_step = 4'b0;
      m_tick = 1'b0; m_active = 1'b0;
`ifdef BUTTON_STEP_ACCEL_EN
      m_in_rep = 1'b0; m_rep = 0;
`endif
   endtask

   initial forever begin
      @(posedge clk_in or negedge rst_n_in);
      if (!rst_n_in) model_reset();
      else model_step();
   end

   initial forever begin
      @(posedge clk_in);
      ncyc++;
   end

   // Compare and tick log, away from the active edge.
   initial forever begin
      @(negedge clk_in);
      check("outputs", dut_vec(), int'({m_stable, m_tick, m_step}));
      held_or = held_or | held;
      if (move_tick) begin
         tick_at.push_back(ncyc);
         tick_mask.push_back({step_south, step_north, step_west, step_east});
         $display("tick cycle=%0d held=%b steps(SNWE)=%b", ncyc, held,
                  {step_south, step_north, step_west, step_east});
      end
   end

   initial begin
      int b;
      set_btn(4'b0);
      wait_cyc(3);
      check("reset_state", dut_vec(), 0);
      rst_n_in = 1'b1;
      wait_cyc(2);

      // Scenario 1: glitches of 1 and 3 cycles never reach held
      clear_log();
      set_btn(M_E); wait_cyc(1); set_btn(4'b0); wait_cyc(8);
      set_btn(M_E); wait_cyc(3); set_btn(4'b0); wait_cyc(12);
      check("glitch_ticks", tick_at.size(), 0);
      check("glitch_held", int'(held_or), 0);

      // Scenario 2: single button, first tick, delay, repeat
      clear_log(); b = ncyc;
      set_btn(M_E); wait_cyc(45);
      check_tick("east_t0", 0, b, 7, M_E);
      check_tick("east_t1", 1, b, 27, M_E);
      check_tick("east_t2", 2, b, 32, M_E);
      check_tick("east_t3", 3, b, 37, M_E);
      set_btn(4'b0); wait_cyc(12);

      // Scenario 3: NORTH joins during repeat without restarting timing
      clear_log(); b = ncyc;
      set_btn(M_E); wait_cyc(38);
      set_btn(M_E | M_N); wait_cyc(17);
      check_tick("join_t4", 4, b, 42, M_E);
`ifdef BUTTON_STEP_ACCEL_EN
      check_tick("join_t5", 5, b, 44, M_E);
      check_tick("join_t6", 6, b, 46, M_E | M_N);
`else
      check_tick("join_t5", 5, b, 47, M_E | M_N);
      check_tick("join_t6", 6, b, 52, M_E | M_N);
`endif
      set_btn(4'b0); wait_cyc(12);

      // Scenario 4: opposing pair cancels strobes, ticks still pulse
      clear_log(); b = ncyc;
      set_btn(M_E | M_W); wait_cyc(35);
      check("ew_held", int'(held), int'(M_E | M_W));
      check_tick("ew_t0", 0, b, 7, 4'b0);
      check_tick("ew_t1", 1, b, 27, 4'b0);
      check_tick("ew_t2", 2, b, 32, 4'b0);
      set_btn(4'b0); wait_cyc(12);

      // Scenario 5: asynchronous reset mid-delay, fresh first tick after
      clear_log();
      set_btn(M_E); wait_cyc(12);
      #2 rst_n_in = 1'b0;
      clear_log();
      #1 check("async_reset", dut_vec(), 0);
      wait_cyc(2);
      rst_n_in = 1'b1; b = ncyc;
      wait_cyc(12);
      check_tick("rst_first", 0, b, 7, M_E);
      set_btn(4'b0); wait_cyc(12);

`ifdef BUTTON_STEP_ACCEL_EN
      // Scenario 6: acceleration after AA repeat ticks, restored on re-press
      clear_log(); b = ncyc;
      set_btn(M_S); wait_cyc(50);
      check_tick("acc_t3", 3, b, 37, M_S);
      check_tick("acc_t4", 4, b, 42, M_S);
      check_tick("acc_t5", 5, b, 44, M_S);
      check_tick("acc_t6", 6, b, 46, M_S);
      check_tick("acc_t7", 7, b, 48, M_S);
      set_btn(4'b0); wait_cyc(12);
      clear_log(); b = ncyc;
      set_btn(M_S); wait_cyc(35);
      check_tick("acc_re_t1", 1, b, 27, M_S);
      check_tick("acc_re_t2", 2, b, 32, M_S);
      set_btn(4'b0); wait_cyc(12);
`endif

      // Random phase: arbitrary button sets and hold lengths, model-checked
      for (int it = 0; it < 150; it++) begin
         set_btn(4'($urandom_range(0, 15)));
         wait_cyc(int'($urandom_range(1, 40)));
      end
      set_btn(4'b0);
      wait_cyc(12);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
